// File: rtl/exec_ctrl.sv
// ---------------------------------------------------------------------------
// exec_ctrl
// Single-issue execute controller. It accepts one operation at a time and
// either hands the operands to an external combinational ALU for one cycle,
// or runs them through an internal 32-step restoring divider. The result
// then sits in a writeback register until the consumer takes it.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds its payload stable until
// that edge. in_ready and wb_valid come from registered state only.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          issue handshake
//   in_aluop/in_val1/in_val2   opcode and operands (dividend/divisor for DIV)
//   in_rd                      destination tag
//   alu_val1/alu_val2/alu_aluop  registered operands/opcode to the ALU
//   alu_is_op                  ALU enable, high only in EXEC
//   alu_result                 ALU combinational result
//   wb_valid/wb_ready          writeback handshake
//   wb_rd/wb_data              writeback tag and value
//   busy                       high whenever not IDLE
//   dbg_state                  current FSM state (IDLE=0 EXEC=1 DIV=2 WB=3)
// ---------------------------------------------------------------------------
module exec_ctrl #(
    parameter logic [4:0] ALUOP_DIV = 5'd6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_aluop,
    input  logic [31:0] in_val1,
    input  logic [31:0] in_val2,
    input  logic [3:0]  in_rd,
    output logic [31:0] alu_val1,
    output logic [31:0] alu_val2,
    output logic [4:0]  alu_aluop,
    output logic        alu_is_op,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_alu_val1;
    logic [31:0] r_alu_val2;
    logic [4:0]  r_alu_aluop;
    logic [3:0]  r_rd;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic        r_wb_valid;
    logic [3:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_is_div;
    logic        w_div_zero;
    logic [32:0] w_partial;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_is_div   = (in_aluop == ALUOP_DIV);
    assign w_div_zero = w_is_div && (in_val2 == 32'd0);

    // Restoring division step. The partial remainder is shifted left and the
    // next dividend bit (held at the top of r_quo) enters at the bottom.
    // Because remainder < divisor, the difference always fits in 33-bit two's
    // complement, so bit 32 of the difference is the borrow.
    assign w_partial  = {r_rem, r_quo[31]};
    assign w_diff     = w_partial - {1'b0, r_alu_val2};
    assign w_ge       = ~w_diff[32];
    assign w_rem_next = w_ge ? w_diff[31:0] : w_partial[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div) begin
                        w_next = S_EXEC;
                    end else if (w_div_zero) begin
                        w_next = S_WB;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_EXEC: w_next = S_WB;
            S_DIV: begin
                if (r_cnt == 5'd31) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_val1  <= '0;
            r_alu_val2  <= '0;
            r_alu_aluop <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_val1  <= in_val1;
                        r_alu_val2  <= in_val2;
                        r_alu_aluop <= in_aluop;
                        r_rd        <= in_rd;
                        r_cnt       <= '0;
                        r_rem       <= '0;
                        r_quo       <= in_val1;
                        // Divide by zero skips the divider entirely.
                        if (w_div_zero) begin
                            r_wb_data  <= 32'hFFFF_FFFF;
                            r_wb_rd    <= in_rd;
                            r_wb_valid <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_wb_data  <= alu_result;
                    r_wb_rd    <= r_rd;
                    r_wb_valid <= 1'b1;
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (r_cnt == 5'd31) begin
                        r_wb_data  <= w_quo_next;
                        r_wb_rd    <= r_rd;
                        r_wb_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign alu_is_op = (r_state == S_EXEC);
    assign alu_val1  = r_alu_val1;
    assign alu_val2  = r_alu_val2;
    assign alu_aluop = r_alu_aluop;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: ALU model driven from the DUT's ALU port, and a
// reference model that computes each result and latency from the request.
module tb_exec_ctrl;

  localparam logic [4:0] OP_DIV = 5'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_aluop = '0;
  logic [31:0] in_val1 = '0;
  logic [31:0] in_val2 = '0;
  logic [3:0]  in_rd = '0;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic [4:0]  alu_aluop;
  logic        alu_is_op;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [35:0] exp_q[$];

  exec_ctrl #(.ALUOP_DIV(OP_DIV)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_val1(in_val1), .in_val2(in_val2), .in_rd(in_rd),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_aluop(alu_aluop),
    .alu_is_op(alu_is_op), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- models ----------------
  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return a << b[4:0];
      5'd7: return a >> b[4:0];
      default: return a + b;
    endcase
  endfunction

  assign alu_result = alu_model(alu_aluop, alu_val1, alu_val2);

  function automatic logic [31:0] exp_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_DIV) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    return alu_model(op, a, b);
  endfunction

  function automatic int exp_latency(input logic [4:0] op, input logic [31:0] b);
    if (op != OP_DIV) return 2;
    return (b == 0) ? 1 : 33;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1;
    in_aluop = op;
    in_val1  = a;
    in_val2  = b;
    in_rd    = rd;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; lat counts edges from accept to the
  // first edge at which wb_valid is seen high.
  task automatic wait_wb(output int lat, output bit seen_is_op, output bit timed_out);
    lat = 1;
    seen_is_op = alu_is_op;
    while (!wb_valid && lat < 100) begin
      tick();
      lat++;
      seen_is_op = seen_is_op | alu_is_op;
    end
    timed_out = !wb_valid;
  endtask

  task automatic do_handshake(output logic [3:0] rd, output logic [31:0] data);
    rd = wb_rd;
    data = wb_data;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    wb_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({dbg_state, busy, wb_valid, alu_is_op} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d busy=%0b wb_valid=%0b is_op=%0b, required 0", dbg_state, busy, wb_valid, alu_is_op);
    end
    checks++;
    if (wb_data !== 32'd0 || wb_rd !== 4'd0) begin
      errors++;
      $display("FAIL reset_wb: data=%h rd=%0d, required 0/0", wb_data, wb_rd);
    end
    checks++;
    if (alu_val1 !== 32'd0 || alu_val2 !== 32'd0 || alu_aluop !== 5'd0) begin
      errors++;
      $display("FAIL reset_alu: v1=%h v2=%h op=%0d, required 0", alu_val1, alu_val2, alu_aluop);
    end
    in_valid = 1'b0;
    wb_ready = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    bit seen, to;
    logic [3:0] rd;
    logic [31:0] d;
    wb_ready = 1'b1;
    drive_issue(5'd0, 32'd5, 32'd7, 4'd3);
    wb_ready = 1'b1;
    checks++;
    if (alu_is_op !== 1'b1 || alu_val1 !== 32'd5 || alu_val2 !== 32'd7 || alu_aluop !== 5'd0) begin
      errors++;
      $display("FAIL add_exec: is_op=%0b v1=%0d v2=%0d op=%0d, required 1/5/7/0", alu_is_op, alu_val1, alu_val2, alu_aluop);
    end
    wait_wb(lat, seen, to);
    checks++;
    if (to || lat != 2) begin
      errors++;
      $display("FAIL add_latency: got %0d (timeout=%0b), required 2", lat, to);
    end
    checks++;
    if (alu_is_op !== 1'b0) begin
      errors++;
      $display("FAIL add_is_op_drop: is_op=%0b in WB, required 0", alu_is_op);
    end
    do_handshake(rd, d);
    checks++;
    if (d !== 32'd12 || rd !== 4'd3) begin
      errors++;
      $display("FAIL add_result: data=%0d rd=%0d, required 12/3", d, rd);
    end
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_after_hs: wb_valid=%0b in_ready=%0b, required 0/1", wb_valid, in_ready);
    end
  endtask

  task automatic test_div();
    int lat;
    bit seen, to;
    logic [3:0] rd;
    logic [31:0] d;
    drive_issue(OP_DIV, 32'd100, 32'd7, 4'd9);
    wait_wb(lat, seen, to);
    checks++;
    if (to || lat != 33 || seen) begin
      errors++;
      $display("FAIL div_latency: got %0d (timeout=%0b is_op_seen=%0b), required 33/0", lat, to, seen);
    end
    do_handshake(rd, d);
    checks++;
    if (d !== 32'd14 || rd !== 4'd9) begin
      errors++;
      $display("FAIL div_result: data=%0d rd=%0d, required 14/9", d, rd);
    end
    drive_issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, 4'd1);
    wait_wb(lat, seen, to);
    do_handshake(rd, d);
    checks++;
    if (to || d !== 32'hFFFF_FFFF || rd !== 4'd1) begin
      errors++;
      $display("FAIL div_max: data=%h rd=%0d timeout=%0b, required ffffffff/1", d, rd, to);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    bit seen, to;
    logic [3:0] rd;
    logic [31:0] d;
    drive_issue(OP_DIV, 32'd42, 32'd0, 4'd5);
    wait_wb(lat, seen, to);
    checks++;
    if (to || lat != 1 || seen) begin
      errors++;
      $display("FAIL div0_latency: got %0d (timeout=%0b is_op_seen=%0b), required 1/0", lat, to, seen);
    end
    do_handshake(rd, d);
    checks++;
    if (d !== 32'hFFFF_FFFF || rd !== 4'd5) begin
      errors++;
      $display("FAIL div0_result: data=%h rd=%0d, required ffffffff/5", d, rd);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen, to;
    logic [3:0] rd;
    logic [31:0] d;
    logic [31:0] a, b;
    // wb_ready in IDLE must do nothing
    wb_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_wb_ready: wb_valid=%0b in_ready=%0b, required 0/1", wb_valid, in_ready);
    end
    wb_ready = 1'b0;
    a = $urandom;
    b = $urandom;
    drive_issue(5'd4, a, b, 4'd12);
    wait_wb(lat, seen, to);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== (a ^ b) || wb_rd !== 4'd12 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%0b data=%h rd=%0d in_ready=%0b, required 1/%h/12/0",
                 i, wb_valid, wb_data, wb_rd, in_ready, a ^ b);
      end
    end
    do_handshake(rd, d);
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0 || d !== (a ^ b)) begin
      errors++;
      $display("FAIL bp_release: in_ready=%0b wb_valid=%0b data=%h, required 1/0/%h", in_ready, wb_valid, d, a ^ b);
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    bit seen, to;
    bit saw_valid = 1'b0;
    logic [3:0] rd;
    logic [31:0] d;
    drive_issue(OP_DIV, 32'd123456, 32'd3, 4'd7);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 4'd0 ||
        alu_is_op !== 1'b0 || alu_val1 !== 32'd0 || alu_val2 !== 32'd0 || alu_aluop !== 5'd0) begin
      errors++;
      $display("FAIL midreset_state: state=%0d busy=%0b valid=%0b data=%h rd=%0d v1=%h v2=%h op=%0d, required all 0",
               dbg_state, busy, wb_valid, wb_data, wb_rd, alu_val1, alu_val2, alu_aluop);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      saw_valid = saw_valid | wb_valid;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL midreset_no_wb: wb_valid seen=%0b, required 0", saw_valid);
    end
    drive_issue(5'd0, 32'd1, 32'd1, 4'd2);
    wait_wb(lat, seen, to);
    do_handshake(rd, d);
    checks++;
    if (to || d !== 32'd2 || rd !== 4'd2) begin
      errors++;
      $display("FAIL midreset_add: data=%0d rd=%0d timeout=%0b, required 2/2", d, rd, to);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    logic [4:0]  ops[N];
    logic [31:0] va[N];
    logic [31:0] vb[N];
    logic [3:0]  vr[N];
    logic [35:0] got;
    logic [35:0] exp;
    int idx = 0;
    int cyc = 0;
    int last_acc = -1;
    int done = 0;
    bit acc, hs;
    for (int i = 0; i < N; i++) begin
      ops[i] = 5'($urandom_range(0, 5));
      va[i]  = $urandom;
      vb[i]  = $urandom;
      vr[i]  = 4'($urandom_range(0, 15));
    end
    exp_q.delete();
    wb_ready = 1'b1;
    in_valid = 1'b1;
    in_aluop = ops[0]; in_val1 = va[0]; in_val2 = vb[0]; in_rd = vr[0];
    while (done < N && cyc < 300) begin
      acc = in_valid && in_ready;
      hs  = wb_valid && wb_ready;
      if (hs) begin
        got = {wb_rd, wb_data};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hX_XXXX_XXXX;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b_result[%0d]: rd/data=%h, required %h", done, got, exp);
        end
        done++;
      end
      if (acc) begin
        exp_q.push_back({vr[idx], exp_result(ops[idx], va[idx], vb[idx])});
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: %0d cycles, required 3", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
      end
      tick();
      cyc++;
      if (idx < N) begin
        in_aluop = ops[idx]; in_val1 = va[idx]; in_val2 = vb[idx]; in_rd = vr[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wb_ready = 1'b0;
    checks++;
    if (done != N || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: results=%0d pending=%0d, required %0d/0", done, exp_q.size(), N);
    end
  endtask

  task automatic test_random();
    int lat;
    bit seen, to;
    logic [3:0] rd;
    logic [31:0] d;
    logic [4:0] op;
    logic [31:0] a, b;
    logic [3:0] r;
    for (int i = 0; i < 16; i++) begin
      op = 5'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 1000));
        default: b = $urandom;
      endcase
      r = 4'($urandom_range(0, 15));
      drive_issue(op, a, b, r);
      wait_wb(lat, seen, to);
      checks++;
      if (to || lat != exp_latency(op, b) || seen != (op != OP_DIV)) begin
        errors++;
        $display("FAIL rand_latency[%0d]: op=%0d lat=%0d is_op_seen=%0b timeout=%0b, required %0d/%0b",
                 i, op, lat, seen, to, exp_latency(op, b), op != OP_DIV);
      end
      for (int k = $urandom_range(0, 3); k > 0; k--) tick();
      do_handshake(rd, d);
      checks++;
      if (d !== exp_result(op, a, b) || rd !== r) begin
        errors++;
        $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h data=%h rd=%0d, required %h/%0d",
                 i, op, a, b, d, rd, exp_result(op, a, b), r);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
